// File: rtl/nnet_pkg.sv
// Shared definitions for the nnet argmax stage.
// Holds the default score/index widths, the FSM state encoding and the
// bit positions of the fields packed into the 32-bit result word.
package nnet_pkg;

    localparam int SCORE_W_DEF = 16;
    localparam int IDX_W_DEF   = 16;

    // Result word layout: {max_score[15:0], index[15:0]}
    localparam int RES_W         = 32;
    localparam int RES_IDX_LSB   = 0;
    localparam int RES_IDX_W     = 16;
    localparam int RES_SCORE_LSB = 16;
    localparam int RES_SCORE_W   = 16;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } argmax_state_t;

endpackage

// File: rtl/nnet_argmax_stage.sv
// nnet_argmax_stage
// Streams a vector of signed scores and emits one result word per vector
// holding the maximum score and the index of its first occurrence.
//
// Ports:
//   clk            compute-engine clock
//   reset          asynchronous active-high reset
//   clear          synchronous flush; drops any partial vector or pending result
//   vec_len        scores per vector, latched on element 0 (0 treated as 1)
//   s_axis_tdata   score in the low SCORE_W bits, upper bits ignored
//   s_axis_tvalid  score valid
//   s_axis_tready  score accept (high while accumulating)
//   m_axis_tdata   {max_score sign-extended/saturated to 16, index[15:0]}
//   m_axis_tlast   end of packet, high with every result word
//   m_axis_tvalid  result valid (high while holding a result)
//   m_axis_tready  downstream accept
//   vec_count      number of result words taken downstream (wraps)
module nnet_argmax_stage
    import nnet_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [IDX_W-1:0] vec_len,
    input  logic [RES_W-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [RES_W-1:0] m_axis_tdata,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [31:0]      vec_count
);

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    // Fit a SCORE_W signed score into the 16-bit result field; wider scores
    // clip to the 16-bit signed range instead of wrapping.
    function automatic logic [RES_SCORE_W-1:0] sat_score(input logic signed [SCORE_W-1:0] s);
        logic [SCORE_W+RES_SCORE_W-1:0] ext;
        logic [SCORE_W:0]               top;
        ext = {{RES_SCORE_W{s[SCORE_W-1]}}, s};
        top = ext[SCORE_W+RES_SCORE_W-1:RES_SCORE_W-1];
        if ((&top) || ~(|top))
            return ext[RES_SCORE_W-1:0];
        else if (s[SCORE_W-1])
            return {1'b1, {(RES_SCORE_W-1){1'b0}}};
        else
            return {1'b0, {(RES_SCORE_W-1){1'b1}}};
    endfunction

    argmax_state_t              state_p0;
    argmax_state_t              state_nxt;
    logic        [IDX_W-1:0]    cnt_p0;
    logic        [IDX_W-1:0]    len_p0;
    logic signed [SCORE_W-1:0]  max_p0;
    logic        [IDX_W-1:0]    idx_p0;

    logic signed [SCORE_W-1:0]  score_in;
    logic        [IDX_W-1:0]    len_eff;
    logic                       first_elem;
    logic                       last_elem;
    logic                       accept;
    logic                       take;
    logic [RES_SCORE_W-1:0]     res_score;
    logic [RES_IDX_W-1:0]       res_idx;
    logic                       unused_tdata;

    assign score_in     = s_axis_tdata[SCORE_W-1:0];
    assign unused_tdata = ^s_axis_tdata;

    // Element 0 sees the live vec_len; later elements use the latched length.
    assign len_eff    = (vec_len == '0) ? IDX_ONE : vec_len;
    assign first_elem = (cnt_p0 == '0);
    assign last_elem  = first_elem ? (len_eff == IDX_ONE)
                                   : (cnt_p0 == (len_p0 - IDX_ONE));

    // ---- control: state register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0 <= ST_ACCUM;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_p0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        accept        = 1'b0;
        take          = 1'b0;
        case (state_p0)
            ST_ACCUM: begin
                s_axis_tready = 1'b1;
                accept        = s_axis_tvalid;
                if (accept && last_elem)
                    state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                take          = m_axis_tready;
                if (take)
                    state_nxt = ST_ACCUM;
            end
            default: state_nxt = ST_ACCUM;
        endcase
        // A flush overrides whatever handshake happens in the same cycle.
        if (clear)
            state_nxt = ST_ACCUM;
    end

    // ---- p0: element counter, running max/index, result count ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_p0    <= '0;
            len_p0    <= '0;
            max_p0    <= '0;
            idx_p0    <= '0;
            vec_count <= '0;
        end else if (clear) begin
            cnt_p0 <= '0;
        end else if (take) begin
            cnt_p0    <= '0;
            vec_count <= vec_count + 32'd1;
        end else if (accept) begin
            cnt_p0 <= cnt_p0 + IDX_ONE;
            if (first_elem) begin
                len_p0 <= len_eff;
                max_p0 <= score_in;
                idx_p0 <= '0;
            end else if (score_in > max_p0) begin
                // Strict compare keeps the earliest index on ties.
                max_p0 <= score_in;
                idx_p0 <= cnt_p0;
            end
        end
    end

    // ---- output: pack result word ----
    assign res_score = sat_score(max_p0);

    if (IDX_W >= RES_IDX_W) begin : g_idx_trunc
        assign res_idx = idx_p0[RES_IDX_W-1:0];
    end else begin : g_idx_pad
        assign res_idx = {{(RES_IDX_W-IDX_W){1'b0}}, idx_p0};
    end

    always_comb begin
        m_axis_tdata = '0;
        m_axis_tdata[RES_SCORE_LSB +: RES_SCORE_W] = res_score;
        m_axis_tdata[RES_IDX_LSB +: RES_IDX_W]     = res_idx;
    end

endmodule

// File: tb/tb_nnet_argmax_stage.sv
// Directed bench for nnet_argmax_stage: hand-computed result words,
// handshake behaviour, clear, length latching and asynchronous reset.
module tb_nnet_argmax_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] vec_len = 16'd0;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [31:0] vec_count;

    int checks = 0;
    int errors = 0;

    nnet_argmax_stage #(.SCORE_W(16), .IDX_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .vec_len       (vec_len),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .vec_count     (vec_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one score at a falling edge; it is taken on the next rising edge.
    task automatic send(input string tag, input logic [31:0] d);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        check(tag, {31'd0, s_axis_tready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] exp);
        check({tag, "_tvalid"}, {31'd0, m_axis_tvalid}, 32'd1);
        check({tag, "_tlast"},  {31'd0, m_axis_tlast},  32'd1);
        check({tag, "_tdata"},  m_axis_tdata, exp);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tdata",  m_axis_tdata, 32'd0);
        check("rst_tlast",  {31'd0, m_axis_tlast}, 32'd0);
        check("rst_tready", {31'd0, s_axis_tready}, 32'd1);
        check("rst_count",  vec_count, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic argmax, back-to-back scores, downstream always ready
        vec_len = 16'd4;
        m_axis_tready = 1'b1;
        send("t1_s0", 32'h0000_0005);
        send("t1_s1", 32'hFFFF_FFFD);
        check("t1_no_early_valid", {31'd0, m_axis_tvalid}, 32'd0);
        send("t1_s2", 32'h0000_0009);
        send("t1_s3", 32'h0000_0002);
        check_result("t1", 32'h0009_0002);
        check("t1_hold_tready", {31'd0, s_axis_tready}, 32'd0);
        @(negedge clk);
        check("t1_done_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("t1_count", vec_count, 32'd1);

        // All-negative scores with a tie
        vec_len = 16'd3;
        send("t2_s0", 32'h0000_FFF9);
        send("t2_s1", 32'h0000_FFFE);
        send("t2_s2", 32'h0000_FFFE);
        check_result("t2", 32'hFFFE_0001);
        @(negedge clk);
        check("t2_count", vec_count, 32'd2);

        // Backpressure: result held, next score stalled and not dropped
        vec_len = 16'd2;
        m_axis_tready = 1'b0;
        send("t3_s0", 32'h0000_000A);
        send("t3_s1", 32'h0000_0014);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h0000_0007;
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_tready", {31'd0, s_axis_tready}, 32'd0);
            check_result("t3_hold", 32'h0014_0001);
            @(negedge clk);
        end
        m_axis_tready = 1'b1;
        @(negedge clk);
        check("t3_released_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("t3_count", vec_count, 32'd3);
        check("t3_ready_again", {31'd0, s_axis_tready}, 32'd1);
        @(negedge clk);
        // Score 7 was element 0 with length 2; a later vec_len change is ignored
        vec_len = 16'd5;
        send("t3_s2", 32'h0000_0003);
        check_result("t3_next", 32'h0007_0000);
        @(negedge clk);
        check("t3_count2", vec_count, 32'd4);

        // Zero length acts as one; upper tdata bits ignored
        vec_len = 16'd0;
        send("t4_s0", 32'hABCD_0042);
        check_result("t4", 32'h0042_0000);
        @(negedge clk);
        check("t4_count", vec_count, 32'd5);

        // Clear discards a partial vector
        vec_len = 16'd4;
        send("t5_s0", 32'h0000_0064);
        send("t5_s1", 32'h0000_0032);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t5_clear_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("t5_clear_count", vec_count, 32'd5);
        send("t5_a0", 32'h0000_0001);
        send("t5_a1", 32'h0000_0002);
        send("t5_a2", 32'h0000_0003);
        check("t5_no_early_valid", {31'd0, m_axis_tvalid}, 32'd0);
        send("t5_a3", 32'h0000_0004);
        check_result("t5", 32'h0004_0003);
        @(negedge clk);
        check("t5_count", vec_count, 32'd6);

        // Clear wins over a simultaneous downstream accept
        vec_len = 16'd1;
        send("t6_s0", 32'h0000_0009);
        check_result("t6", 32'h0009_0000);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t6_clear_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("t6_clear_count", vec_count, 32'd6);

        // Asynchronous reset while holding a result
        vec_len = 16'd2;
        m_axis_tready = 1'b0;
        send("t7_s0", 32'h0000_0001);
        send("t7_s1", 32'h0000_0002);
        check_result("t7_pre", 32'h0002_0001);
        #2 reset = 1'b1;
        #1;
        check("t7_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("t7_rst_tdata",  m_axis_tdata, 32'd0);
        check("t7_rst_tlast",  {31'd0, m_axis_tlast}, 32'd0);
        check("t7_rst_tready", {31'd0, s_axis_tready}, 32'd1);
        check("t7_rst_count",  vec_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_axis_tready = 1'b1;
        vec_len = 16'd3;
        @(negedge clk);
        check("t7_idle_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        send("t7_a0", 32'h0000_FFFF);
        send("t7_a1", 32'h0000_FFFB);
        send("t7_a2", 32'h0000_0004);
        check_result("t7", 32'h0004_0002);
        @(negedge clk);
        check("t7_count", vec_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nnet_argmax_stage.md
NNET_ARGMAX_STAGE -- requirements
Module: nnet_argmax_stage

Interface
REQ-001 SHALL have parameter SCORE_W, default 16, signed score width taken from s_axis_tdata[SCORE_W-1:0].
REQ-002 SHALL have parameter IDX_W, default 16, width of the class index and length counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports, in this order:
- clk  in  1  compute-engine clock
- reset  in  1  asynchronous, active-high
- clear  in  1  synchronous flush, driven by clear_tx_seqnum
- vec_len  in  IDX_W  scores per vector (the HLS const_size_out)
- s_axis_tdata  in  32  score, in the low SCORE_W bits; upper bits ignored
- s_axis_tvalid  in  1  score valid (res_V_V_write)
- s_axis_tready  out  1  accept (res_V_V_full_n)
- m_axis_tdata  out  32  result word: {max_score sign-extended to 16, index[15:0]}
- m_axis_tlast  out  1  end of result packet
- m_axis_tvalid  out  1  result valid
- m_axis_tready  in  1  downstream accept
- vec_count  out  32  count of completed result words

Function
REQ-005 SHALL implement a two-state FSM: ACCUM (consuming scores) and HOLD (presenting a result).
REQ-006 In ACCUM, s_axis_tready SHALL be 1 and m_axis_tvalid SHALL be 0.
REQ-007 In HOLD, s_axis_tready SHALL be 0 and m_axis_tvalid SHALL be 1.
REQ-008 A score SHALL be accepted on a cycle with s_axis_tvalid=1 and s_axis_tready=1.
REQ-009 vec_len SHALL be latched on acceptance of element 0 of each vector; changes mid-vector SHALL have no effect until the next vector.
REQ-010 A latched length of 0 SHALL be treated as 1.
REQ-011 Element 0 SHALL unconditionally load max=score and idx=0.
REQ-012 Each later element SHALL replace max/idx only if score > max under a signed compare.
REQ-013 On ties the lowest index SHALL win.
REQ-014 The element counter SHALL increment per accepted score.
REQ-015 Acceptance of element len-1 SHALL transition ACCUM->HOLD; m_axis_tvalid SHALL assert the next cycle, giving one-cycle latency from the last score.
REQ-016 The final element SHALL take part in the compare before the result is registered.
REQ-017 m_axis_tdata and m_axis_tlast SHALL be stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-018 m_axis_tlast SHALL be 1 whenever m_axis_tvalid=1, so each result is a single-word packet.
REQ-019 On m_axis_tready=1 in HOLD, the FSM SHALL return to ACCUM, clear the counter and increment vec_count.
REQ-020 vec_count SHALL wrap from 2^32-1 to 0.
REQ-021 clear=1 SHALL force ACCUM and counter=0, discarding a partial vector or an unaccepted result without incrementing vec_count.
REQ-022 clear SHALL take priority over any simultaneous handshake.
REQ-023 Scores presented while in HOLD SHALL be back-pressured, never dropped.

Reset
REQ-024 On reset assertion, all state SHALL clear asynchronously: state=ACCUM, counter=0, max=0, idx=0, vec_count=0.
REQ-025 Outputs during reset SHALL be: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=1.
REQ-026 Reset mid-vector or mid-HOLD SHALL abandon the vector and emit no result.

Structure
REQ-027 A shared package nnet_pkg SHALL hold the SCORE_W and IDX_W defaults, the FSM state encoding and the result-word field positions.
REQ-028 No sub-module is needed; the compare/update datapath SHALL be inline in nnet_argmax_stage.

Verification
REQ-029 vec_len=4, scores 5,-3,9,2 back-to-back, m_axis_tready=1 -> one word 0x00090002, tlast=1, one cycle after the last score; vec_count=1.
REQ-030 vec_len=3, scores -7,-2,-2 -> 0xFFFE0001 (tie resolved to the lower index; signed compare).
REQ-031 vec_len=2 with m_axis_tready=0 for 5 cycles, third score offered -> s_axis_tready=0 throughout, tdata held; after accept, the third score is taken as element 0 of the next vector.
REQ-032 vec_len=0, score 0x0042 -> 0x00420000 after a single score.
REQ-033 Two scores of a 4-vector, then clear pulse, then 4 scores 1,2,3,4 -> single result 0x00040003; vec_count=1.
REQ-034 reset asserted during HOLD -> m_axis_tvalid drops immediately (asynchronously); vec_count=0; the next vector's result is correct.
